// File: rtl/aes_pkg.sv
// aes_pkg: shared constants, tables and helpers for the iterative AES-128 engine.
//   NUM_ROUNDS    - rounds in an AES-128 encryption
//   eng_state_e   - engine control states
//   sbox()        - SubBytes lookup
//   xtime()       - multiply by x in GF(2^8)
//   rcon_of()     - key-schedule round constant for rounds 1..10 (0 elsewhere)
//   unroll_legal()- legal rounds-per-clock values
package aes_pkg;

    localparam int unsigned NUM_ROUNDS = 10;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } eng_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] a);
        return SBOX[a];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic bit unroll_legal(input int unsigned u);
        return (u == 1) || (u == 2) || (u == 5) || (u == 10);
    endfunction

endpackage

// File: rtl/aes_round.sv
// aes_round: one combinational AES-128 encryption round plus one key-schedule step.
//   state_in  - state entering the round (byte 0 = bits 0..7, column-major)
//   key_in    - previous round key
//   rcon      - round constant for this round
//   is_final  - final round: MixColumns is skipped
//   state_out - SubBytes/ShiftRows/[MixColumns]/AddRoundKey(key_out) result
//   key_out   - round key for this round
module aes_round
    import aes_pkg::*;
(
    input  logic [0:127] state_in,
    input  logic [0:127] key_in,
    input  logic [0:7]   rcon,
    input  logic         is_final,
    output logic [0:127] state_out,
    output logic [0:127] key_out
);

    logic [7:0]  sr [16];
    logic [7:0]  mc [16];
    logic [31:0] w  [4];
    logic [31:0] nw [4];
    logic [31:0] tw;

    // SubBytes with ShiftRows folded in: output (row r, col c) takes input column c+r.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c + r] = sbox(state_in[8*(4*((c + r) % 4) + r) +: 8]);
            end
        end
    end

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            mc[4*c]     = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c + 1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c + 2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c + 3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
    end

    // Key schedule: RotWord + SubWord of the last word, XOR Rcon into the top byte.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            w[j] = key_in[32*j +: 32];
        end
        tw = {sbox(w[3][23:16]), sbox(w[3][15:8]), sbox(w[3][7:0]), sbox(w[3][31:24])}
             ^ {rcon, 24'h000000};
        nw[0] = w[0] ^ tw;
        nw[1] = w[1] ^ nw[0];
        nw[2] = w[2] ^ nw[1];
        nw[3] = w[3] ^ nw[2];
    end

    assign key_out = {nw[0], nw[1], nw[2], nw[3]};

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            state_out[8*i +: 8] = (is_final ? sr[i] : mc[i]) ^ key_out[8*i +: 8];
        end
    end

endmodule

// File: rtl/aes_iter_engine.sv
// aes_iter_engine: iterative AES-128 encryption, UNROLL rounds per clock.
//   UNROLL    - rounds per clock (1, 2, 5 or 10)
//   clk, rst  - clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready / key_in / data_in - block input handshake
//   out_valid / out_ready / data_out       - ciphertext output handshake
//   busy      - high while rounds are being computed
module aes_iter_engine
    import aes_pkg::*;
#(
    parameter int unsigned UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] key_in,
    input  logic [0:127] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] data_out,
    output logic         busy
);

    if (!unroll_legal(UNROLL)) begin : g_bad_unroll
        $error("aes_iter_engine: UNROLL must be 1, 2, 5 or 10");
    end

    eng_state_e   state_q, state_d;
    logic [0:127] st_q, st_d;
    logic [0:127] rk_q, rk_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [0:127] st_last, rk_last;
    logic         last_step;

    // Round chain: stage i processes round rnd_q+i.
    for (genvar i = 0; i < UNROLL; i++) begin : g_round
        logic [0:127] st_in, rk_in, st_out, rk_out;
        logic [3:0]   r;

        assign r = rnd_q + 4'(i);

        if (i == 0) begin : g_head
            assign st_in = st_q;
            assign rk_in = rk_q;
        end else begin : g_link
            assign st_in = g_round[i-1].st_out;
            assign rk_in = g_round[i-1].rk_out;
        end

        aes_round u_round (
            .state_in (st_in),
            .key_in   (rk_in),
            .rcon     (rcon_of(r)),
            .is_final (r == 4'(NUM_ROUNDS)),
            .state_out(st_out),
            .key_out  (rk_out)
        );
    end

    assign st_last = g_round[UNROLL-1].st_out;
    assign rk_last = g_round[UNROLL-1].rk_out;

    // Round 10 lies inside this cycle's chain.
    assign last_step = (5'(rnd_q) + 5'(UNROLL)) > 5'(NUM_ROUNDS);

    always_comb begin
        state_d   = state_q;
        st_d      = st_q;
        rk_d      = rk_q;
        rnd_d     = rnd_q;
        in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
        out_valid = (state_q == StDone);
        busy      = (state_q == StRun);

        case (state_q)
            StIdle: ;
            StRun: begin
                st_d  = st_last;
                rk_d  = rk_last;
                rnd_d = rnd_q + 4'(UNROLL);
                if (last_step) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Accept overrides DONE->IDLE so a waiting block goes straight into RUN.
        if (in_valid && in_ready) begin
            st_d    = data_in ^ key_in;
            rk_d    = key_in;
            rnd_d   = 4'd1;
            state_d = StRun;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            st_q    <= '0;
            rk_q    <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            rk_q    <= rk_d;
            rnd_q   <= rnd_d;
        end
    end

    assign data_out = st_q;

endmodule

// File: tb/tb_aes_iter_engine.sv
// tb_aes_iter_engine: checks four engine instances (UNROLL 1/2/5/10) sharing one input bus
// against a byte-array AES-128 reference model and published test vectors.
module tb_aes_iter_engine;

    localparam int NI = 4;

    localparam logic [0:127] C1_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] C1_P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] C1_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] KF_K = 128'h5468617473206d79204b756e67204675;
    localparam logic [0:127] KF_P = 128'h54776f204f6e65204e696e652054776f;
    localparam logic [0:127] KF_C = 128'h29c3505f571420f6402299b31a02d73a;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, out_ready;
    logic [0:127] key_in, data_in;
    logic         ir [NI];
    logic         ov [NI];
    logic         bz [NI];
    logic [0:127] dout [NI];

    int errors = 0;
    int checks = 0;
    logic [7:0] sb [256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned U = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10;
        aes_iter_engine #(.UNROLL(U)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid),
            .in_ready (ir[g]),
            .key_in   (key_in),
            .data_in  (data_in),
            .out_valid(ov[g]),
            .out_ready(out_ready),
            .data_out (dout[g]),
            .busy     (bz[g])
        );
    end

    function automatic int lat_of(input int g);
        case (g)
            0:       return 10;
            1:       return 5;
            2:       return 2;
            default: return 1;
        endcase
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    // S-box from the GF(2^8) inverse and the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++) begin
                if (gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
            end
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [0:127] ref_encrypt(input logic [0:127] key, input logic [0:127] pt);
        logic [7:0]   w [44][4];
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   tmp [4];
        logic [7:0]   rc = 8'h01;
        logic [0:127] res;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) w[i][j] = key[32*i + 8*j +: 8];
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-1][j];
            if (i % 4 == 0) begin
                for (int j = 0; j < 4; j++) tmp[j] = sb[w[i-1][(j + 1) % 4]];
                tmp[0] = tmp[0] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ tmp[j];
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[r][c] = pt[8*(4*c + r) +: 8] ^ w[c][r];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) t[r][c] = sb[s[r][(c + r) % 4]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    if (rnd < 10)
                        s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c])
                                  ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
                    else
                        s[r][c] = t[r][c];
                end
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) s[r][c] = s[r][c] ^ w[4*rnd + c][r];
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) res[8*(4*c + r) +: 8] = s[r][c];
        return res;
    endfunction

    function automatic logic [0:127] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();
        rst = 1'b1;
    endtask

    // One block with out_ready low for the whole run; checks latency, busy length, result.
    task automatic run_block(input logic [0:127] k, input logic [0:127] p,
                             input logic [0:127] e, input bit r1, input string nm);
        int lat [NI];
        int bcnt [NI];
        for (int i = 0; i < NI; i++) begin
            lat[i] = -1;
            bcnt[i] = 0;
        end
        chk({nm, "_in_ready"}, ir[0], 1'b1);
        key_in = k;
        data_in = p;
        in_valid = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        for (int n = 0; n < 14; n++) begin
            for (int i = 0; i < NI; i++) begin
                if (bz[i]) bcnt[i]++;
                if (ov[i] && lat[i] < 0) lat[i] = n;
            end
            if (r1 && n == 1) begin
                chk({nm, "_r1_state"}, g_dut[0].u_dut.st_q,
                    128'h5847088b15b61cba59d4e2e8cd39dfce);
                chk({nm, "_r1_key"}, g_dut[0].u_dut.rk_q,
                    128'he232fcf191129188b159e4e6d679a293);
            end
            step();
        end
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s_ct_u%0d", nm, i), dout[i], e);
            chk($sformatf("%s_lat_u%0d", nm, i), lat[i], lat_of(i));
            chk($sformatf("%s_busy_u%0d", nm, i), bcnt[i], lat_of(i));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({nm, "_ov_drop"}, ov[0], 1'b0);
    endtask

    typedef struct {
        logic [0:127] key;
        logic [0:127] pt;
        logic [0:127] ct;
        bit           r1;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int hits [$];
        int rises [NI];
        logic prev [NI];
        logic [0:127] rk, rp, re;

        build_sbox();
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        key_in = '0;
        data_in = '0;
        step();
        step();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_in_ready_u%0d", i), ir[i], 1'b1);
            chk($sformatf("rst_out_valid_u%0d", i), ov[i], 1'b0);
            chk($sformatf("rst_busy_u%0d", i), bz[i], 1'b0);
            chk($sformatf("rst_data_out_u%0d", i), dout[i], 128'h0);
        end
        rst = 1'b1;

        // Table: published vectors plus random ones scored by the model.
        vecs[0] = '{key: C1_K, pt: C1_P, ct: C1_C, r1: 1'b0};
        vecs[1] = '{key: KF_K, pt: KF_P, ct: KF_C, r1: 1'b1};
        for (int v = 2; v < 6; v++) begin
            vecs[v].key = rand128();
            vecs[v].pt  = rand128();
            vecs[v].ct  = ref_encrypt(vecs[v].key, vecs[v].pt);
            vecs[v].r1  = 1'b0;
        end
        for (int v = 0; v < 6; v++) begin
            run_block(vecs[v].key, vecs[v].pt, vecs[v].ct, vecs[v].r1, $sformatf("vec%0d", v));
        end

        // Backpressure, then accept on the releasing edge.
        do_reset();
        key_in = C1_K;
        data_in = C1_P;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int n = 1; n <= 10; n++) step();
        chk("bp_ov", ov[0], 1'b1);
        for (int n = 0; n < 7; n++) begin
            step();
            chk("bp_hold_data", dout[0], C1_C);
            chk("bp_hold_in_ready", ir[0], 1'b0);
        end
        key_in = KF_K;
        data_in = KF_P;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", ir[0], 1'b1);
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("bp_next_busy", bz[0], 1'b1);
        chk("bp_next_ov", ov[0], 1'b0);
        for (int n = 1; n <= 10; n++) step();
        chk("bp_next_ct", dout[0], KF_C);
        chk("bp_next_ov_hi", ov[0], 1'b1);

        // Back-to-back with valid/ready tied high.
        do_reset();
        key_in = C1_K;
        data_in = C1_P;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 34; n++) begin
            step();
            if (ov[0]) begin
                hits.push_back(n);
                chk("b2b_ct", dout[0], C1_C);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("b2b_count", hits.size(), 3);
        chk("b2b_first", hits.size() > 0 ? hits[0] : -1, 10);
        chk("b2b_second", hits.size() > 1 ? hits[1] : -1, 21);
        chk("b2b_third", hits.size() > 2 ? hits[2] : -1, 32);

        // Reset mid-RUN while round 4 is being computed.
        do_reset();
        key_in = C1_K;
        data_in = C1_P;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int n = 1; n <= 3; n++) step();
        chk("mid_busy_before", bz[0], 1'b1);
        #2;
        rst = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("mid_ov_u%0d", i), ov[i], 1'b0);
            chk($sformatf("mid_busy_u%0d", i), bz[i], 1'b0);
            chk($sformatf("mid_in_ready_u%0d", i), ir[i], 1'b1);
        end
        chk("mid_data_out", dout[0], 128'h0);
        step();
        rst = 1'b1;
        run_block(C1_K, C1_P, C1_C, 1'b0, "post_rst");

        // Inputs toggled while busy must not disturb the result.
        do_reset();
        rk = rand128();
        rp = rand128();
        re = ref_encrypt(rk, rp);
        key_in = rk;
        data_in = rp;
        in_valid = 1'b1;
        step();
        for (int i = 0; i < NI; i++) begin
            rises[i] = 0;
            prev[i] = 1'b0;
        end
        for (int n = 0; n < 14; n++) begin
            for (int i = 0; i < NI; i++) begin
                if (ov[i] && !prev[i]) rises[i]++;
                prev[i] = ov[i];
            end
            in_valid = 1'($urandom);
            key_in = rand128();
            data_in = rand128();
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("ign_ct_u%0d", i), dout[i], re);
            chk($sformatf("ign_pulses_u%0d", i), rises[i], 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_iter_engine.md
# aes_iter_engine

- Parametrised AES-128 encryption engine; successor to the single-cycle round block.
- Wraps a combinational round (SubBytes, ShiftRows, MixColumns, AddRoundKey, plus on-the-fly key-schedule step) in a round counter and state machine.
- Computes `UNROLL` rounds per clock, so one encryption takes 10/`UNROLL` cycles. Round 10 automatically omits MixColumns.
- Sits between the block-mode front end and the output formatter, with valid/ready handshakes on both sides.

## Interface

- `UNROLL`, default 1: rounds computed per clock. Legal values are 1, 2, 5 and 10; any other value is an elaboration error.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-low.
- `in_valid` input, 1 bit: `key_in`/`data_in` valid.
- `in_ready` output, 1 bit: engine can accept a block.
- `key_in` input, [0:127]: cipher key. Byte 0 is bits 0..7.
- `data_in` input, [0:127]: plaintext block, same byte order.
- `out_valid` output, 1 bit: `data_out` holds a finished ciphertext.
- `out_ready` input, 1 bit: downstream accepts `data_out`.
- `data_out` output, [0:127]: ciphertext.
- `busy` output, 1 bit: high in RUN.

## Operation

- States:
  - IDLE: `in_ready`=1.
  - RUN: rounds in progress.
  - DONE: result held.
- Accept: `in_valid && in_ready` at a rising edge.
  - State register ← `data_in` XOR `key_in`.
  - Round-key register ← `key_in`.
  - `rnd` ← 1.
  - Go to RUN.
- RUN, each cycle:
  - Apply `UNROLL` chained round instances to rounds `rnd` .. `rnd+UNROLL-1`.
  - Instance for round r uses Rcon[r]. It is the final round (no MixColumns) iff r==10.
  - Register the state and the last round key; `rnd` ← `rnd+UNROLL`.
  - If round 10 was in this cycle's chain, go to DONE.
- DONE:
  - `out_valid`=1.
  - `data_out` = state register, stable until handshake.
- Leaving DONE on `out_ready`:
  - To IDLE if `in_valid`=0.
  - If `in_valid`=1 in the same cycle, accept the new block directly (back-to-back); the next state is RUN.
- `in_ready` = (state==IDLE) || (state==DONE && `out_ready`). Combinational, no dependence on `in_valid`.
- `rnd` is a 4-bit counter holding 1..11. The value 11 is reached only on the transition into DONE, is never used to index Rcon, and resets to 0.
- Inputs are ignored (not sampled) in RUN and in DONE without `out_ready`.
- Reset asserted at any time, including mid-RUN:
  - Immediately: state=IDLE, `out_valid`=0, `busy`=0.
  - Data registers and `data_out` = 0, `rnd`=0.
  - The partial result is discarded; no output handshake occurs.
- After reset: `in_ready`=1 as soon as `rst` deasserts.

## Timing

- Reset values: `in_ready`=1, `out_valid`=0, `busy`=0, `data_out`=128'h0.
- Latency:
  - Accept edge at cycle k; `out_valid` rises after edge k+10/`UNROLL`.
  - `UNROLL`=1: 10 cycles. `UNROLL`=2: 5. `UNROLL`=5: 2. `UNROLL`=10: 1.
- Throughput with `out_ready` held high: one block every 10/`UNROLL`+1 cycles.
  - The DONE cycle overlaps the next accept, so 11 cycles per block at `UNROLL`=1.
- Backpressure: `out_valid` stays high and `data_out` unchanged for any number of cycles until `out_ready`=1.
- `busy` is high for exactly 10/`UNROLL` cycles per block.
- Critical path is `UNROLL` chained rounds. `UNROLL`=10 is for low-clock/characterisation builds only.

## Structure

- Package `aes_pkg`:
  - S-box table/function, `xtime`, Rcon[1..10] constants.
  - `NUM_ROUNDS`=10.
  - State enum (IDLE/RUN/DONE).
  - Function checking legal `UNROLL`.
- Sub-module `aes_round`:
  - Purely combinational.
  - Inputs: `state_in` [0:127], `key_in` [0:127], `rcon` [0:7], `final` (1 bit).
  - Outputs: `state_out`, `key_out`.
  - Generated `UNROLL` times in a chain inside `aes_iter_engine`.
  - Shares no registers with the engine.

## Test plan

- FIPS-197 C.1, `UNROLL`=1: key 000102030405060708090A0B0C0D0E0F, pt 00112233445566778899AABBCCDDEEFF.
  - Expect `data_out`=69C4E0D86A7B0430D8CDB78070B4C55A.
  - `out_valid` exactly 10 cycles after accept; `busy` high 10 cycles.
- Key 5468617473206D79204B756E67204675, pt 54776F204F6E65204E696E652054776F, repeated for each of `UNROLL`=1/2/5/10.
  - Expect 29C3505F571420F6402299B31A02D73A with latency 10/5/2/1.
  - At `UNROLL`=1, internal state after cycle 1 = 5847088B15B61CBA59D4E2E8CD39DFCE and round key = E232FCF191129188B159E4E6D679A293.
- Backpressure: hold `out_ready`=0 for 7 cycles after `out_valid`.
  - `data_out` constant, `in_ready`=0.
  - On `out_ready`=1 with `in_valid`=1, the next block is accepted the same edge.
- Back-to-back: three C.1 blocks with `in_valid`/`out_ready` tied high.
  - Three identical ciphertexts at 11-cycle spacing (`UNROLL`=1).
- Reset mid-RUN: drive `rst`=0 at round 4.
  - `out_valid`=0, `busy`=0, `in_ready`=1 immediately.
  - A following C.1 block produces the correct ciphertext.
- Input ignore: toggle `in_valid` and `key_in` during RUN.
  - Result is unaffected; no extra `out_valid` pulses.
